joypad_if: RTL

- Serial interface between the two NES controller ports and the CPU joypad registers ($4016/$4017).
- An FSM drives jp_latch/jp_clk and shifts 8 bits in from each pad into snapshot registers. Polling is autonomous and periodic, or on request.
- The CPU side emulates strobe/shift semantics on the shared OR'd read bus, so d_out is 8'h00 whenever the block is not selected.

---
 rtl/joypad_if.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/joypad_if.sv
// joypad_if: NES controller serial interface and CPU $4016/$4017 port emulation.
// A poll FSM drives jp_latch_out/jp_clk_out, shifts 8 bits in from each pad and
// publishes them as pad snapshots. Polls start periodically (POLL_PERIOD) or on
// poll_in. The CPU side emulates strobe/shift semantics on an OR'd read bus.
// Optional build macro JP_DEBOUNCE_EN: a snapshot only changes after two
// consecutive polls return the same raw value.
`timescale 1ns/1ps
module joypad_if #(
    parameter int HALF_CLK    = 6,
    parameter int POLL_PERIOD = 416666
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       poll_in,
    input  logic       jp_data1_in,
    input  logic       jp_data2_in,
    output logic       jp_clk_out,
    output logic       jp_latch_out,
    input  logic       reg_sel_in,
    input  logic       rd_in,
    input  logic       wr_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       busy_out,
    output logic [7:0] pad1_out,
    output logic [7:0] pad2_out
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_CLK_HI = 3'd3;
    localparam logic [2:0] ST_CLK_LO = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int            TW         = $clog2(2 * HALF_CLK + 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_CLK - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CLK - 1);

    localparam bit            AUTO_EN    = (POLL_PERIOD > 0);
    localparam int            PW         = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST  = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    logic [2:0]    state_r, state_nxt_s;
    logic [TW-1:0] tmr_r, tmr_nxt_s;
    logic [2:0]    bit_r, bit_nxt_s;
    logic          leave_idle_s;
    logic          pending_r;
    logic          auto_tick_s;
    logic [PW-1:0] poll_cnt_r;
    logic [7:0]    tmp1_r, tmp2_r;
    logic          strobe_r;
    logic [7:0]    sr1_r, sr2_r;

    assign auto_tick_s = AUTO_EN && (poll_cnt_r == POLL_LAST);

    // Free-running auto-poll divider; the wrap cycle raises a poll request.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            poll_cnt_r <= '0;
        end else if (!AUTO_EN || poll_cnt_r == POLL_LAST) begin
            poll_cnt_r <= '0;
        end else begin
            poll_cnt_r <= poll_cnt_r + PW'(1);
        end
    end

    // Pending request flag: any trigger wins over the clear, so triggers during a poll coalesce into one follow-up poll.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_r <= 1'b0;
        end else if (poll_in || auto_tick_s) begin
            pending_r <= 1'b1;
        end else if (leave_idle_s) begin
            pending_r <= 1'b0;
        end
    end

    // Poll FSM next-state, phase timer and bit index.
    always_comb begin
        state_nxt_s  = state_r;
        tmr_nxt_s    = tmr_r;
        bit_nxt_s    = bit_r;
        leave_idle_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    state_nxt_s  = ST_LATCH;
                    tmr_nxt_s    = '0;
                    leave_idle_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (tmr_r == LATCH_LAST) begin
                    state_nxt_s = ST_SAMPLE;
                    tmr_nxt_s   = '0;
                    bit_nxt_s   = 3'd0;
                end else begin
                    tmr_nxt_s   = tmr_r + TW'(1);
                end
            end
            ST_SAMPLE: begin
                tmr_nxt_s = '0;
                if (bit_r == 3'd7) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (tmr_r == HALF_LAST) begin
                    state_nxt_s = ST_CLK_LO;
                    tmr_nxt_s   = '0;
                end else begin
                    tmr_nxt_s   = tmr_r + TW'(1);
                end
            end
            ST_CLK_LO: begin
                if (tmr_r == HALF_LAST) begin
                    state_nxt_s = ST_SAMPLE;
                    tmr_nxt_s   = '0;
                    bit_nxt_s   = bit_r + 3'd1;
                end else begin
                    tmr_nxt_s   = tmr_r + TW'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tmr_nxt_s   = '0;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    // FSM state plus registered pad-side outputs decoded from the next state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= ST_IDLE;
            tmr_r        <= '0;
            bit_r        <= 3'd0;
            jp_latch_out <= 1'b0;
            jp_clk_out   <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            tmr_r        <= tmr_nxt_s;
            bit_r        <= bit_nxt_s;
            jp_latch_out <= (state_nxt_s == ST_LATCH);
            jp_clk_out   <= (state_nxt_s == ST_CLK_HI);
            busy_out     <= (state_nxt_s != ST_IDLE);
        end
    end

    // Capture one inverted (active-low pin to 1=pressed) bit per pad in SAMPLE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tmp1_r <= 8'h00;
            tmp2_r <= 8'h00;
        end else if (state_r == ST_SAMPLE) begin
            tmp1_r[bit_r] <= ~jp_data1_in;
            tmp2_r[bit_r] <= ~jp_data2_in;
        end
    end

`ifdef JP_DEBOUNCE_EN
    logic [7:0] prev1_r, prev2_r;

    // Publish a pad value only when it matches the previous poll's raw value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prev1_r  <= 8'h00;
            prev2_r  <= 8'h00;
            pad1_out <= 8'h00;
            pad2_out <= 8'h00;
        end else if (state_r == ST_DONE) begin
            prev1_r <= tmp1_r;
            prev2_r <= tmp2_r;
            if (tmp1_r == prev1_r) begin
                pad1_out <= tmp1_r;
            end
            if (tmp2_r == prev2_r) begin
                pad2_out <= tmp2_r;
            end
        end
    end
`else
    // Publish the freshly shifted pad values at the end of every poll.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pad1_out <= 8'h00;
            pad2_out <= 8'h00;
        end else if (state_r == ST_DONE) begin
            pad1_out <= tmp1_r;
            pad2_out <= tmp2_r;
        end
    end
`endif

    // CPU strobe latch; only $4016 writes reach it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            strobe_r <= 1'b0;
        end else if (wr_in && !reg_sel_in) begin
            strobe_r <= d_in[0];
        end
    end

    // CPU-visible shift registers: reload while strobe is high, else shift one bit per read with 1 filling from the top.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sr1_r <= 8'hFF;
            sr2_r <= 8'hFF;
        end else if (strobe_r) begin
            sr1_r <= pad1_out;
            sr2_r <= pad2_out;
        end else begin
            if (rd_in && !reg_sel_in) begin
                sr1_r <= {1'b1, sr1_r[7:1]};
            end
            if (rd_in && reg_sel_in) begin
                sr2_r <= {1'b1, sr2_r[7:1]};
            end
        end
    end

    // Read data: open-bus pattern 0x40 plus the current serial bit; zero when not read so the bus can be OR'd.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            d_out <= 8'h00;
        end else if (rd_in) begin
            d_out <= {7'b0100000, (reg_sel_in ? sr2_r[0] : sr1_r[0])};
        end else begin
            d_out <= 8'h00;
        end
    end

endmodule
